// File: rtl/mhd_pair_gen.sv
// rtl/mhd_pair_gen.sv - LFSR-driven operand pair source with exact Hamming distance (optional checker: MHD_GEN_SELFCHECK_EN)
module mhd_pair_gen #(
    parameter int          WIDTH = 18,
    parameter logic [31:0] SEED  = 32'h1,
    parameter int          HDW   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [HDW-1:0]   target_hd,
    input  logic [15:0]      num_pairs,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [HDW-1:0]   out_hd,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // A zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [31:0]    SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0]    LFSR_FB  = 32'hA3000000;
    localparam logic [HDW-1:0] WIDTH_HD = HDW'(WIDTH);
    localparam logic [5:0]     WIDTH_IX = 6'(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [31:0]        lfsr_q;
    logic [WIDTH-1:0]   a_q;
    logic [31:0]        mask_q;
    logic [HDW-1:0]     set_q;
    logic [HDW-1:0]     hd_q;
    logic [15:0]        cnt_q;

    logic [31:0]        lfsr_next;
    logic [4:0]         idx;
    logic               idx_ok;
    logic [HDW-1:0]     clamped_hd;

    // Next LFSR value, candidate bit index and clamped distance.
    always_comb begin
        lfsr_next  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_FB : 32'h0);
        idx        = lfsr_q[4:0];
        idx_ok     = ({1'b0, idx} < WIDTH_IX);
        clamped_hd = (target_hd > WIDTH_HD) ? WIDTH_HD : target_hd;
    end

    // Control FSM with registered outputs; BUILD tests completion before it adds a bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED_EFF;
            a_q       <= '0;
            mask_q    <= '0;
            set_q     <= '0;
            hd_q      <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_hd    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        hd_q  <= clamped_hd;
                        cnt_q <= num_pairs;
                        if (num_pairs != 16'd0) begin
                            state_q <= BUILD;
                            busy    <= 1'b1;
                            a_q     <= lfsr_q[WIDTH-1:0];
                            mask_q  <= '0;
                            set_q   <= '0;
                        end else begin
                            state_q <= DONE;
                            done    <= 1'b1;
                        end
                    end
                end
                BUILD: begin
                    lfsr_q <= lfsr_next;
                    if (set_q == hd_q) begin
                        state_q   <= EMIT;
                        out_valid <= 1'b1;
                        out_a     <= a_q;
                        out_b     <= a_q ^ mask_q[WIDTH-1:0];
                        out_hd    <= hd_q;
                    end else if (idx_ok && !mask_q[idx] && (set_q < hd_q)) begin
                        mask_q[idx] <= 1'b1;
                        set_q       <= set_q + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        lfsr_q    <= lfsr_next;
                        cnt_q     <= cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_q <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_q <= BUILD;
                            a_q     <= lfsr_q[WIDTH-1:0];
                            mask_q  <= '0;
                            set_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MHD_GEN_SELFCHECK_EN
    function automatic logic [HDW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [HDW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + HDW'(v[i]);
        end
        return c;
    endfunction

    logic err_q;

    // Sticky flag: distance of each accepted pair must match its reported distance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (out_valid && out_ready && (popcount(out_a ^ out_b) != out_hd)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mhd_pair_gen.sv
// tb/tb_mhd_pair_gen.sv - directed vector bench for mhd_pair_gen
module tb_mhd_pair_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  target_hd = '0;
    logic [15:0] num_pairs = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [17:0] out_a;
    logic [17:0] out_b;
    logic [5:0]  out_hd;
    logic        busy;
    logic        done;
    logic        err;

    int vec_cnt = 0;
    int fail_cnt = 0;

    typedef struct {
        logic [5:0]  tgt;
        logic [15:0] num;
        logic [5:0]  exp_hd;
    } vec_t;

    vec_t vecs[6];

    mhd_pair_gen #(.WIDTH(18), .SEED(32'h1), .HDW(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .target_hd (target_hd),
        .num_pairs (num_pairs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_hd    (out_hd),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int popcnt(input logic [17:0] v);
        int c = 0;
        for (int i = 0; i < 18; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic wait_valid(input string name, output bit saw_done);
        int c = 0;
        saw_done = 1'b0;
        while (!out_valid && c < 4000) begin
            step();
            if (done) saw_done = 1'b1;
            c++;
        end
        chk(name, 32'(out_valid), 32'd1);
    endtask

    task automatic pulse_start(input logic [5:0] tgt, input logic [15:0] num);
        start = 1'b1;
        target_hd = tgt;
        num_pairs = num;
        step();
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int pairs = 0;
        int cyc = 0;
        bit seen_done = 1'b0;
        logic [17:0] inv;
        out_ready = 1'b1;
        pulse_start(v.tgt, v.num);
        while (!seen_done && cyc < 8000) begin
            if (out_valid) begin
                pairs++;
                chk("pair_hd", 32'(out_hd), 32'(v.exp_hd));
                chk("pair_popcount", popcnt(out_a ^ out_b), 32'(v.exp_hd));
                if (v.exp_hd == 6'd18) begin
                    inv = ~out_a;
                    chk("pair_inverse", 32'(out_b), 32'(inv));
                end
                if (k == 0 && pairs == 1) chk("first_a_seed", 32'(out_a), 32'h1);
            end
            if (done) seen_done = 1'b1;
            else begin
                step();
                cyc++;
            end
        end
        chk("run_done_seen", 32'(seen_done), 32'd1);
        chk("run_pair_count", pairs, 32'(v.num));
        chk("run_err", 32'(err), 32'd0);
        chk("run_busy_clear", 32'(busy), 32'd0);
        step();
        chk("run_done_single", 32'(done), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        bit sd;
        logic [17:0] ca, cb;
        logic [5:0]  ch;
        bit stable;

        vecs[0] = '{tgt: 6'd0,  num: 16'd4, exp_hd: 6'd0};
        vecs[1] = '{tgt: 6'd18, num: 16'd2, exp_hd: 6'd18};
        vecs[2] = '{tgt: 6'd40, num: 16'd1, exp_hd: 6'd18};
        vecs[3] = '{tgt: 6'd5,  num: 16'd3, exp_hd: 6'd5};
        vecs[4] = '{tgt: 6'd1,  num: 16'd2, exp_hd: 6'd1};
        vecs[5] = '{tgt: 6'd17, num: 16'd1, exp_hd: 6'd17};

        // reset state
        step();
        step();
        chk("reset_outputs", {out_valid, busy, done, err, out_hd, out_a, out_b} == '0, 32'd1);
        rst_n = 1'b1;
        step();

        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

        // stall: outputs hold while out_ready is low, one count consumed per release
        out_ready = 1'b0;
        pulse_start(6'd5, 16'd2);
        wait_valid("stall_wait1", sd);
        ca = out_a; cb = out_b; ch = out_hd;
        chk("stall_hd", 32'(ch), 32'd5);
        chk("stall_popcount", popcnt(ca ^ cb), 32'd5);
        for (int i = 0; i < 20; i++) begin
            step();
            stable = out_valid && (out_a == ca) && (out_b == cb) && (out_hd == ch);
            chk("stall_stable", 32'(stable), 32'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("stall_valid_drop", 32'(out_valid), 32'd0);
        chk("stall_busy_remain", 32'(busy), 32'd1);
        chk("stall_no_done", 32'(done), 32'd0);
        wait_valid("stall_wait2", sd);
        chk("stall_no_early_done", 32'(sd), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("stall_done", 32'(done), 32'd1);
        step();

        // reset during BUILD aborts the run
        out_ready = 1'b1;
        pulse_start(6'd18, 16'd3);
        step();
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_in_build", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_reset_outputs", {out_valid, busy, done, err, out_hd, out_a, out_b} == '0, 32'd1);
        step();
        chk("abort_no_done1", 32'(done), 32'd0);
        step();
        chk("abort_no_done2", 32'(done), 32'd0);
        rst_n = 1'b1;
        step();
        chk("abort_idle_no_done", 32'(done), 32'd0);
        pulse_start(6'd3, 16'd1);
        wait_valid("rerun_wait", sd);
        chk("rerun_a_seed", 32'(out_a), 32'h1);
        chk("rerun_popcount", popcnt(out_a ^ out_b), 32'd3);
        step();
        chk("rerun_done", 32'(done), 32'd1);
        out_ready = 1'b0;
        step();

        // zero pairs goes straight to DONE
        pulse_start(6'd4, 16'd0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_no_valid", 32'(out_valid), 32'd0);
        chk("zero_not_busy", 32'(busy), 32'd0);
        step();
        chk("zero_done_pulse", 32'(done), 32'd0);

        // start while busy is ignored
        pulse_start(6'd4, 16'd1);
        chk("ign_busy", 32'(busy), 32'd1);
        pulse_start(6'd0, 16'd0);
        chk("ign_no_done_build", 32'(done), 32'd0);
        wait_valid("ign_wait", sd);
        chk("ign_wait_no_done", 32'(sd), 32'd0);
        chk("ign_hd", 32'(out_hd), 32'd4);
        pulse_start(6'd0, 16'd0);
        chk("ign_no_done_emit", 32'(done), 32'd0);
        chk("ign_valid_held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ign_done", 32'(done), 32'd1);
        step();
        chk("ign_done_pulse", 32'(done), 32'd0);
        chk("ign_idle", 32'(busy), 32'd0);
        chk("final_err", 32'(err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/mhd_pair_gen.md
# mhd_pair_gen

Sequential stimulus source for the Hamming-distance miter flow: it streams operand pairs (a, b) where b differs from a in exactly a programmed number of bit positions. It sits upstream of the miter comparator in approximate-circuit evaluation benches and emulation harnesses, and provides the write side of the a/b pair interface that the miter consumes. Pairs leave through a valid/ready handshake. A run ends after a programmed pair count.

## Interface
- WIDTH, 18, operand width; legal range 1..32
- SEED, 32'h1, LFSR reset seed; zero is illegal and is forced to 32'h1
- HDW, 6, width of distance fields; must satisfy 2^HDW > WIDTH

- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- start  input  1  one-cycle pulse; accepted only in IDLE
- target_hd  input  HDW  required distance; latched on start
- num_pairs  input  16  number of pairs to emit; latched on start; 0 means no pairs (direct to DONE)
- out_valid  output  1  pair valid
- out_ready  input  1  consumer accepts the pair
- out_a  output  WIDTH  reference operand
- out_b  output  WIDTH  out_a XOR flip mask
- out_hd  output  HDW  distance actually applied (clamped target)
- busy  output  1  high in BUILD or EMIT
- done  output  1  one-cycle pulse when the run completes
- err  output  1  sticky self-check failure (see Configuration)

## Operation
- LFSR: 32-bit Galois, right shift, feedback mask 32'hA3000000. Advances every cycle in BUILD and once on each accepted pair. Otherwise holds.
- Clamp on start: hd_q = min(target_hd, WIDTH). cnt_q = num_pairs.
- FSM IDLE -> BUILD on start with num_pairs != 0. IDLE -> DONE on start with num_pairs == 0.
- Entering BUILD: a_q = lfsr[WIDTH-1:0], mask = 0, set = 0.
- BUILD, each cycle: idx = lfsr[4:0]. If idx < WIDTH, mask[idx] == 0, and set < hd_q, then set mask[idx] and increment set. When set == hd_q, go to EMIT on the next edge; the check is made before the per-cycle update.
- EMIT: out_valid = 1; out_a = a_q; out_b = a_q ^ mask; out_hd = hd_q. All outputs hold stable until out_ready.
- On handshake (out_valid && out_ready) cnt_q decrements. If cnt_q becomes 0, go to DONE. Otherwise go to BUILD with fresh a_q and a cleared mask.
- DONE: done = 1 for one cycle, then IDLE.
- start outside IDLE is ignored.
- hd_q == WIDTH: the mask ends all-ones, so out_b = ~out_a.

## Timing
- Reset values: out_valid 0, out_a 0, out_b 0, out_hd 0, busy 0, done 0, err 0. LFSR = SEED, FSM = IDLE.
- Reset mid-run aborts immediately. No done pulse. Any pending pair is dropped.
- Latency from start to first out_valid is at least 2 cycles: 1 cycle to enter BUILD plus at least max(hd_q,1) BUILD cycles. It is unbounded in theory but is bounded in practice by the LFSR period.
- Back-to-back handshakes are impossible; at least one BUILD cycle separates consecutive pairs.
- out_ready while out_valid is 0 has no effect. out_valid never drops without a handshake, except on reset.

## Configuration
- MHD_GEN_SELFCHECK_EN defined: an internal popcount of out_a ^ out_b is compared with out_hd on every handshake. On a mismatch err is set and stays set until reset.
- Not defined: the checker is not built and err is tied to 0.

## Test plan
- target_hd=0, num_pairs=4, out_ready=1 -> 4 pairs, each with out_b == out_a and out_hd=0; done pulses once; err=0.
- target_hd=18, num_pairs=2 -> out_b == ~out_a (within 18 bits) and out_hd=18.
- target_hd=40 (over WIDTH) -> clamped: out_hd=18, popcount(a^b)=18.
- target_hd=5, out_ready held low 20 cycles after out_valid -> out_a, out_b and out_hd stay stable; exactly one count is consumed on release.
- rst_n pulsed low during BUILD with num_pairs=3 -> all outputs return to reset values and no done pulse occurs; a new start runs normally with the LFSR back at SEED.
- num_pairs=0 with start -> no out_valid; done pulses 1 cycle after start; start pulsed during busy is ignored.
